// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared state encoding and opcode constants for the cpu sequencer
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_HALT    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC1   = 3'd2,
    S_EXEC2   = 3'd3,
    S_STOPPED = 3'd4
  } seq_state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1001;
  localparam logic [3:0] OP_LSR = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - wrapping up-counter with synchronous clear and count enable
module seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - run-control FSM producing FETCH/EXEC1/EXEC2 strobes plus cycle/instruction counters
// Optional breakpoint halt at instruction boundaries is enabled by SEQ_BREAKPOINT_EN.
module cpu_sequencer #(
  parameter int         CNT_W  = 16,
  parameter int         ADDR_W = 12,
  parameter logic [3:0] OP_STP = cpu_seq_pkg::OP_STP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              restart,
  input  logic [3:0]        IR,
  input  logic              EXTRA,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              halted,
  output logic              stopped,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  ins_cnt
);
  import cpu_seq_pkg::*;

  seq_state_t state, state_nxt;
  logic       step_flag, step_nxt;
  logic       at_b;
  logic       bp_match;

`ifdef SEQ_BREAKPOINT_EN
  assign bp_match = bp_en && (pc == bp_addr);
`else
  assign bp_match = 1'b0;
  logic unused_bp;
  assign unused_bp = &{1'b0, bp_en, bp_addr, pc};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HALT;
      step_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_flag <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step_flag;
    at_b      = 1'b0;
    case (state)
      S_HALT: begin
        if (step || (run && !halt_req)) begin
          state_nxt = S_FETCH;
          step_nxt  = step;
        end
      end
      S_FETCH:   state_nxt = S_EXEC1;
      S_EXEC1: begin
        if (EXTRA) state_nxt = S_EXEC2;
        else       at_b      = 1'b1;
      end
      S_EXEC2:   at_b = 1'b1;
      S_STOPPED: if (restart) state_nxt = S_HALT;
      default:   state_nxt = S_HALT;
    endcase
    // Instruction boundary: STP beats breakpoint beats the ordinary stop conditions.
    if (at_b) begin
      step_nxt = 1'b0;
      if (IR == OP_STP)
        state_nxt = S_STOPPED;
      else if (bp_match || step_flag || halt_req || !run)
        state_nxt = S_HALT;
      else
        state_nxt = S_FETCH;
    end
  end

`ifdef SEQ_BREAKPOINT_EN
  logic bp_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      bp_q <= 1'b0;
    else if (state == S_HALT && state_nxt == S_FETCH)
      bp_q <= 1'b0;
    else if (at_b && IR != OP_STP && bp_match)
      bp_q <= 1'b1;
  end
  assign bp_hit = bp_q;
`else
  assign bp_hit = 1'b0;
`endif

  assign FETCH   = (state == S_FETCH);
  assign EXEC1   = (state == S_EXEC1);
  assign EXEC2   = (state == S_EXEC2);
  assign halted  = (state == S_HALT) || (state == S_STOPPED);
  assign stopped = (state == S_STOPPED);

  seq_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (FETCH || EXEC1 || EXEC2),
    .count (cyc_cnt)
  );

  seq_counter #(.W(CNT_W)) u_ins_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (at_b),
    .count (ins_cnt)
  );

endmodule
